maxpool_reduce_buffer: RTL



---
 rtl/cnn_pkg.sv | 23 ++
 rtl/max2_s16.sv | 13 +
 rtl/maxpool_reduce_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: activation word, pooling geometry helper, pooling FSM states.
package cnn_pkg;

    localparam int unsigned ACT_BITS = 16;

    typedef logic signed [ACT_BITS-1:0] act_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } mp_state_t;

    // Output extent of a valid (no padding) pooling pass along one axis.
    function automatic int unsigned pool_out_dim(
        input int unsigned in_dim,
        input int unsigned k,
        input int unsigned s
    );
        return (in_dim - k) / s + 1;
    endfunction

endpackage

// File: rtl/max2_s16.sv
// Combinational signed 16-bit two-input maximum.
module max2_s16
    import cnn_pkg::*;
(
    input  act_t a_i,
    input  act_t b_i,
    output act_t max_c
);

    // Ties pick a_i; both operands are equal so the result is the same.
    assign max_c = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/maxpool_reduce_buffer.sv
// 2x2 signed max-pool reduction with a 2-stage compare pipeline writing a flop-based pooled map.
// Optional build macro MAXPOOL_RELU_EN clamps negative results to zero before the write.
module maxpool_reduce_buffer
    import cnn_pkg::*;
#(
    parameter  int unsigned ACT_W  = 26,
    parameter  int unsigned ACT_H  = 26,
    parameter  int unsigned POOL_K = 2,
    parameter  int unsigned POOL_S = 2,
    localparam int unsigned OUT_W  = pool_out_dim(ACT_W, POOL_K, POOL_S),
    localparam int unsigned OUT_H  = pool_out_dim(ACT_H, POOL_K, POOL_S),
    localparam int unsigned N_OUT  = OUT_W * OUT_H,
    localparam int unsigned IDX_W  = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             win_valid,
    input  act_t             win0,
    input  act_t             win1,
    input  act_t             win2,
    input  act_t             win3,
    output act_t             pooled_map [0:N_OUT-1],
    output logic             wr_valid,
    output logic [IDX_W-1:0] wr_idx,
    output act_t             wr_data,
    output logic             map_done,
    output logic             map_ready,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_TAG = IDX_W'(N_OUT - 1);

    mp_state_t        state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             accept_c;
    logic [IDX_W-1:0] tag_c;

    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_tag_q, s1_tag_d;
    act_t             m01_q, m01_d;
    act_t             m23_q, m23_d;

    act_t             m01_c, m23_c, max_c, result_c;
    logic             wr_en_c, last_c;

    logic             wr_valid_q, wr_valid_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    act_t             wr_data_q, wr_data_d;
    logic             map_done_q, map_done_d;
    logic             map_ready_q, map_ready_d;
    logic             overrun_q, overrun_d;

    act_t             pooled_map_q [0:N_OUT-1];

    // Stage-1 pairwise compares feed off the raw window; stage 2 reduces the registered pair.
    max2_s16 u_max_top (.a_i(win0),  .b_i(win1),  .max_c(m01_c));
    max2_s16 u_max_bot (.a_i(win2),  .b_i(win3),  .max_c(m23_c));
    max2_s16 u_max_fin (.a_i(m01_q), .b_i(m23_q), .max_c(max_c));

`ifdef MAXPOOL_RELU_EN
    assign result_c = max_c[ACT_BITS-1] ? '0 : max_c;
`else
    assign result_c = max_c;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Acceptance control; start restarts the frame and wins over every other transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_c  = 1'b0;
        tag_c     = cnt_q;
        overrun_d = overrun_q;
        if (start) begin
            state_d   = COLLECT;
            overrun_d = 1'b0;
            tag_c     = '0;
            accept_c  = win_valid;
            cnt_d     = win_valid ? IDX_W'(1) : '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (win_valid) begin
                        accept_c = 1'b1;
                        if (cnt_q == LAST_TAG) begin
                            state_d = FULL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + IDX_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (win_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A start in the same cycle kills whatever sits in stage 1.
    always_comb begin
        s1_valid_d  = accept_c;
        s1_tag_d    = s1_tag_q;
        m01_d       = m01_q;
        m23_d       = m23_q;
        if (accept_c) begin
            s1_tag_d = tag_c;
            m01_d    = m01_c;
            m23_d    = m23_c;
        end

        wr_en_c     = s1_valid_q && !start;
        last_c      = wr_en_c && (s1_tag_q == LAST_TAG);

        wr_valid_d  = wr_en_c;
        wr_idx_d    = wr_en_c ? s1_tag_q : wr_idx_q;
        wr_data_d   = wr_en_c ? result_c : wr_data_q;
        map_done_d  = last_c;
        map_ready_d = start ? 1'b0 : (map_ready_q || last_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            m01_q       <= '0;
            m23_q       <= '0;
            wr_valid_q  <= 1'b0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            map_done_q  <= 1'b0;
            map_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            m01_q       <= m01_d;
            m23_q       <= m23_d;
            wr_valid_q  <= wr_valid_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            map_done_q  <= map_done_d;
            map_ready_q <= map_ready_d;
            overrun_q   <= overrun_d;
        end
    end

    // Flop array so the dense stage can read every pooled entry in parallel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_OUT; i++) begin
                pooled_map_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            pooled_map_q[s1_tag_q] <= result_c;
        end
    end

    assign pooled_map = pooled_map_q;
    assign wr_valid   = wr_valid_q;
    assign wr_idx     = wr_idx_q;
    assign wr_data    = wr_data_q;
    assign map_done   = map_done_q;
    assign map_ready  = map_ready_q;
    assign overrun    = overrun_q;

endmodule
